// File: rtl/mrelbp_ci_sched.sv
// Frame scheduler for the R2/R4/R6 MRELBP CI pipelines: collects one histogram per radius,
// then streams them out in R2, R4, R6 order on a valid/ready port, with a collection watchdog.
module mrelbp_ci_sched #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             done_r2_i,
    input  logic [CNT_W-1:0] one_r2_i,
    input  logic [CNT_W-1:0] zero_r2_i,
    input  logic             done_r4_i,
    input  logic [CNT_W-1:0] one_r4_i,
    input  logic [CNT_W-1:0] zero_r4_i,
    input  logic             done_r6_i,
    input  logic [CNT_W-1:0] one_r6_i,
    input  logic [CNT_W-1:0] zero_r6_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [1:0]       out_radius_o,
    output logic [CNT_W-1:0] out_one_o,
    output logic [CNT_W-1:0] out_zero_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_timeout_o,
    output logic             err_overrun_o
);
    // state   | meaning
    // IDLE    | waiting for start_i
    // COLLECT | capturing per-radius counts, watchdog running
    // SEND    | presenting entry[idx] on the result port
    // DONE    | one-cycle frame_done_o pulse

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The abort edge is the one on which the counter would reach TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [2:0]                flag, flag_nxt;
    logic [2:0][CNT_W-1:0]     one_q, one_nxt;
    logic [2:0][CNT_W-1:0]     zero_q, zero_nxt;
    logic [WD_W-1:0]           wdog, wdog_nxt;
    logic [1:0]                idx, idx_nxt;
    logic                      tout_q, tout_nxt;
    logic                      ovr_q, ovr_nxt;
    logic                      all_seen;
    logic [2:0]                done_vec;
    logic [2:0][CNT_W-1:0]     one_in;
    logic [2:0][CNT_W-1:0]     zero_in;
    logic [CNT_W-1:0]          sel_one, sel_zero;

    assign done_vec = {done_r6_i, done_r4_i, done_r2_i};
    assign one_in   = {one_r6_i, one_r4_i, one_r2_i};
    assign zero_in  = {zero_r6_i, zero_r4_i, zero_r2_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            flag   <= '0;
            one_q  <= '0;
            zero_q <= '0;
            wdog   <= '0;
            idx    <= '0;
            tout_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            flag   <= flag_nxt;
            one_q  <= one_nxt;
            zero_q <= zero_nxt;
            wdog   <= wdog_nxt;
            idx    <= idx_nxt;
            tout_q <= tout_nxt;
            ovr_q  <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flag_nxt  = flag;
        one_nxt   = one_q;
        zero_nxt  = zero_q;
        wdog_nxt  = wdog;
        idx_nxt   = idx;
        tout_nxt  = tout_q;
        ovr_nxt   = ovr_q;
        all_seen  = &(flag | done_vec);
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_COLLECT;
                    flag_nxt  = '0;
                    wdog_nxt  = '0;
                    tout_nxt  = 1'b0;
                    ovr_nxt   = 1'b0;
                end
            end
            ST_COLLECT: begin
                for (int i = 0; i < 3; i++) begin
                    if (done_vec[i]) begin
                        if (flag[i]) begin
                            ovr_nxt = 1'b1;
                        end else begin
                            one_nxt[i]  = one_in[i];
                            zero_nxt[i] = zero_in[i];
                            flag_nxt[i] = 1'b1;
                        end
                    end
                end
                // Completion wins over a watchdog expiry on the same edge.
                if (all_seen) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                    if (wdog == WD_LAST) begin
                        tout_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (|done_vec) ovr_nxt = 1'b1;
                if (out_ready_i) begin
                    if (idx == 2'd2) state_nxt = ST_DONE;
                    else             idx_nxt   = idx + 2'd1;
                end
            end
            ST_DONE: begin
                if (|done_vec) ovr_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_one  = '0;
        sel_zero = '0;
        case (idx)
            2'd0: begin sel_one = one_q[0]; sel_zero = zero_q[0]; end
            2'd1: begin sel_one = one_q[1]; sel_zero = zero_q[1]; end
            2'd2: begin sel_one = one_q[2]; sel_zero = zero_q[2]; end
            default: begin sel_one = '0; sel_zero = '0; end
        endcase
    end

    assign out_valid_o   = (state == ST_SEND);
    assign out_radius_o  = out_valid_o ? idx : 2'd0;
    assign out_one_o     = out_valid_o ? sel_one : '0;
    assign out_zero_o    = out_valid_o ? sel_zero : '0;
    assign busy_o        = (state != ST_IDLE);
    assign frame_done_o  = (state == ST_DONE);
    assign err_timeout_o = tout_q;
    assign err_overrun_o = ovr_q;

endmodule
